// File: rtl/sreg_ser_tx.sv
// Parallel-to-serial transmitter feeding an N-bit serial-in shift register, LSB first.
// Optional macro FRAME_CNT_EN adds an 8-bit completed-frame counter output fcnt.
module sreg_ser_tx #(
  parameter int N   = 4,
  parameter int GAP = 1
) (
  input  logic         ck,
  input  logic         rn,
  input  logic [N-1:0] din,
  input  logic         load,
  output logic         rdy,
  output logic         sout,
  output logic         done
`ifdef FRAME_CNT_EN
  ,
  output logic [7:0]   fcnt
`endif
);

  localparam int BW = $clog2(N);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [BW-1:0] N_LAST   = BW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  shreg, shreg_nxt;
  logic [BW-1:0] bitcnt, bitcnt_nxt;
  logic [GW-1:0] gapcnt, gapcnt_nxt;
  logic          sout_nxt, done_nxt;

  assign rdy = (state == IDLE) && rn;

  always_ff @(posedge ck) begin
    if (!rn) state <= IDLE;
    else     state <= state_nxt;
  end

  // The word is pre-shifted at capture so that shreg[0] always holds the next bit to send.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    gapcnt_nxt = gapcnt;
    sout_nxt   = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt  = SHIFT;
          shreg_nxt  = din >> 1;
          sout_nxt   = din[0];
          bitcnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (bitcnt == N_LAST) begin
          state_nxt  = GAPW;
          bitcnt_nxt = '0;
          gapcnt_nxt = '0;
          done_nxt   = 1'b1;
        end else begin
          bitcnt_nxt = bitcnt + 1'b1;
          sout_nxt   = shreg[0];
          shreg_nxt  = shreg >> 1;
        end
      end
      GAPW: begin
        if (gapcnt == GAP_LAST) begin
          state_nxt  = IDLE;
          gapcnt_nxt = '0;
        end else begin
          gapcnt_nxt = gapcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rn) begin
      shreg  <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
      sout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      shreg  <= shreg_nxt;
      bitcnt <= bitcnt_nxt;
      gapcnt <= gapcnt_nxt;
      sout   <= sout_nxt;
      done   <= done_nxt;
    end
  end

`ifdef FRAME_CNT_EN
  // Counts on the done-setting edge, so a frame cut short by reset never reaches it.
  always_ff @(posedge ck) begin
    if (!rn)           fcnt <= '0;
    else if (done_nxt) fcnt <= fcnt + 8'd1;
  end
`endif

endmodule
